// File: rtl/elevator_counter_if.sv
// Elevator floor-position bus: counter controls/state plus the direction
// calculator's compare inputs and move commands.
interface elevator_counter_if #(
    parameter int WIDTH = 4
);
    // Counter side
    logic             en;
    logic             load;
    logic             up_down;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] count;

    // Direction calculator side
    logic [WIDTH-1:0] F;
    logic [WIDTH-1:0] C;
    logic             calc_en;
    logic             calc_up_down;

    // Driver of the block (controller / bench)
    modport master (
        output en, load, up_down, data, F, C,
        input  count, calc_en, calc_up_down
    );

    // The elevator_counter block itself
    modport slave (
        input  en, load, up_down, data, F, C,
        output count, calc_en, calc_up_down
    );
endinterface

// File: rtl/elevator_counter.sv
// Elevator floor-position unit: a WIDTH-bit up/down floor counter with
// synchronous load, plus a combinational direction calculator. In the
// datapath calc_en/calc_up_down feed en/up_down and count feeds C; both
// halves are kept independent here so each can be driven on its own.
module elevator_counter #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    elevator_counter_if.slave  bus
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_next;

    // Next floor: load beats stepping; stepping wraps silently both ways.
    always_comb begin
        count_next = count_q;
        if (bus.load) begin
            count_next = bus.data;
        end else if (bus.en) begin
            if (bus.up_down) begin
                count_next = count_q + WIDTH'(1);
            end else begin
                count_next = count_q - WIDTH'(1);
            end
        end
    end

    // Floor register; reset clears it at once, regardless of the clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_next;
        end
    end

    assign bus.count = count_q;

    // Direction calculator: move whenever floors differ, go up only when
    // the target is strictly above. Unsigned over the full WIDTH range.
    assign bus.calc_en      = (bus.F != bus.C);
    assign bus.calc_up_down = (bus.F > bus.C);

endmodule

// File: tb/tb_elevator_counter.sv
// Scoreboard bench for elevator_counter: stimulus pushes expectations and
// raises a sample event; a monitor pops and compares against the DUT.
module tb_elevator_counter;

    localparam int W = 4;

    typedef struct {
        int         kind;   // 0 = count, 1 = calculator outputs
        logic [3:0] cnt;
        logic       ce;
        logic       cud;
        string      name;
    } item_t;

    logic clk;
    logic reset;

    elevator_counter_if #(.WIDTH(W)) bus ();

    elevator_counter #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    item_t sb[$];
    event  sample_ev;
    int    checks = 0;
    int    errors = 0;

    // Monitor: compare each presented sample with the oldest expectation.
    initial begin
        item_t it;
        forever begin
            @(sample_ev);
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_empty: sample with no expectation");
            end else begin
                it = sb.pop_front();
                if (it.kind == 0) begin
                    if (bus.count !== it.cnt) begin
                        errors++;
                        $display("FAIL %s: count=%0d expected=%0d", it.name, bus.count, it.cnt);
                    end
                end else begin
                    if (bus.calc_en !== it.ce || bus.calc_up_down !== it.cud) begin
                        errors++;
                        $display("FAIL %s: F=%0d C=%0d calc_en=%b calc_up_down=%b expected=%b%b",
                                 it.name, bus.F, bus.C, bus.calc_en, bus.calc_up_down, it.ce, it.cud);
                    end
                end
            end
        end
    end

    task automatic chk_count(input logic [3:0] e, input string name);
        item_t it;
        it.kind = 0; it.cnt = e; it.ce = 1'b0; it.cud = 1'b0; it.name = name;
        sb.push_back(it);
        -> sample_ev;
        #1;
    endtask

    task automatic chk_calc(input logic ce, input logic cud, input string name);
        item_t it;
        it.kind = 1; it.cnt = '0; it.ce = ce; it.cud = cud; it.name = name;
        sb.push_back(it);
        -> sample_ev;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    logic [3:0] up_seq [5]  = '{4'd4, 4'd5, 4'd6, 4'd7, 4'd7};
    logic [3:0] dn_seq [7]  = '{4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd1};
    // {F, C, calc_en, calc_up_down} for out-of-normal-range floors
    logic [9:0] bnd [8] = '{
        {4'd15, 4'd0,  1'b1, 1'b1},
        {4'd0,  4'd15, 1'b1, 1'b0},
        {4'd12, 4'd12, 1'b0, 1'b0},
        {4'd10, 4'd9,  1'b1, 1'b1},
        {4'd9,  4'd10, 1'b1, 1'b0},
        {4'd15, 4'd14, 1'b1, 1'b1},
        {4'd14, 4'd15, 1'b1, 1'b0},
        {4'd15, 4'd15, 1'b0, 1'b0}
    };

    initial begin
        reset = 1'b1;
        bus.en = 1'b0; bus.load = 1'b0; bus.up_down = 1'b0;
        bus.data = '0; bus.F = '0; bus.C = '0;

        // Reset held for two edges, with other controls active meanwhile
        step();
        chk_count(4'd0, "rst_hold0");
        bus.en = 1'b1; bus.up_down = 1'b1; bus.load = 1'b1; bus.data = 4'd9;
        step();
        chk_count(4'd0, "rst_hold1");
        reset = 1'b0; bus.en = 1'b0; bus.load = 1'b0;
        step();
        chk_count(4'd0, "idle0");
        step();
        chk_count(4'd0, "idle1");

        // Count up through the wrap: 1..15, 0, 1..4
        bus.en = 1'b1; bus.up_down = 1'b1;
        for (int i = 0; i < 20; i++) begin
            logic [3:0] e;
            e = 4'((i + 1) % 16);
            step();
            chk_count(e, "count_up");
        end

        // Load 2, then count down through the wrap, then hold
        bus.load = 1'b1; bus.data = 4'd2;
        step();
        chk_count(4'd2, "load2");
        bus.load = 1'b0; bus.up_down = 1'b0;
        step(); chk_count(4'd1,  "down1");
        step(); chk_count(4'd0,  "down0");
        step(); chk_count(4'd15, "down_wrap15");
        step(); chk_count(4'd14, "down14");
        bus.en = 1'b0;
        step(); chk_count(4'd14, "hold14a");
        step(); chk_count(4'd14, "hold14b");

        // Load beats counting
        bus.en = 1'b1; bus.up_down = 1'b1; bus.load = 1'b1; bus.data = 4'd7;
        step(); chk_count(4'd7, "load_prio");
        bus.load = 1'b0;
        step(); chk_count(4'd8, "after_load");
        bus.up_down = 1'b0; bus.load = 1'b1; bus.data = 4'd15;
        step(); chk_count(4'd15, "load_prio_dn");
        bus.load = 1'b0;
        step(); chk_count(4'd14, "after_load_dn");

        // Asynchronous reset between edges while counting
        bus.up_down = 1'b1;
        step(); chk_count(4'd15, "pre_async");
        #2;
        reset = 1'b1;
        #1;
        chk_count(4'd0, "async_rst");
        step(); chk_count(4'd0, "async_hold");
        reset = 1'b0;
        step(); chk_count(4'd1, "post_rst");

        // Closed loop: calculator drives counter toward F, no overshoot
        bus.en = 1'b0;
        bus.load = 1'b1; bus.data = 4'd3;
        step(); chk_count(4'd3, "loop_load3");
        bus.load = 1'b0;
        bus.F = 4'd7;
        for (int i = 0; i < 5; i++) begin
            bus.C = bus.count;
            #1;
            bus.en = bus.calc_en; bus.up_down = bus.calc_up_down;
            step();
            chk_count(up_seq[i], "loop_up");
        end
        bus.F = 4'd1;
        for (int i = 0; i < 7; i++) begin
            bus.C = bus.count;
            #1;
            bus.en = bus.calc_en; bus.up_down = bus.calc_up_down;
            step();
            chk_count(dn_seq[i], "loop_dn");
        end
        bus.en = 1'b0;

        // Calculator sweep over normal floors
        for (int f = 0; f < 10; f++) begin
            for (int c = 0; c < 10; c++) begin
                bus.F = 4'(f); bus.C = 4'(c);
                #1;
                chk_calc(f != c, f > c, "calc_sweep");
            end
        end

        // Calculator on floors 10..15
        for (int i = 0; i < 8; i++) begin
            logic [9:0] v;
            v = bnd[i];
            bus.F = v[9:6]; bus.C = v[5:2];
            #1;
            chk_calc(v[1], v[0], "calc_bound");
        end

        // Drain scoreboard (bounded)
        for (int i = 0; i < 10 && sb.size() != 0; i++) #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d expectations left, expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
